// File: rtl/dma_axi_mem_slave.sv
// dma_axi_mem_slave: AXI4 slave RAM with independent single-burst read and write engines
package dma_utils_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_USER_W = 1;
  localparam logic [1:0] AXI_OKAY    = 2'b00;
  localparam logic [1:0] AXI_SLVERR  = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  typedef struct packed {
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic [AXI_USER_W-1:0] buser;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [AXI_USER_W-1:0] ruser;
    logic                  rvalid;
  } s_axi_miso_t;
endpackage

module dma_axi_mem_slave
  import dma_utils_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);
  localparam int          BPW       = AXI_DATA_W / 8;
  localparam int          BSH       = $clog2(BPW);
  localparam int          IW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * BPW);
  localparam logic [2:0]  MAX_SIZE  = 3'(BSH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

  w_state_t            w_state, w_state_n;
  logic [AXI_ID_W-1:0] w_id, w_id_n;
  logic [31:0]         w_addr, w_addr_n;
  logic [7:0]          w_len, w_len_n, w_cnt, w_cnt_n;
  logic [2:0]          w_size, w_size_n;
  logic [1:0]          w_burst, w_burst_n;
  logic                w_err, w_err_n, w_we;

  r_state_t            r_state, r_state_n;
  logic [AXI_ID_W-1:0] r_id, r_id_n;
  logic [31:0]         r_addr, r_addr_n;
  logic [7:0]          r_len, r_len_n, r_cnt, r_cnt_n;
  logic [2:0]          r_size, r_size_n;
  logic [1:0]          r_burst, r_burst_n;
  logic                r_in;

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> BSH);
  endfunction

  // FIXED holds the address; INCR and WRAP both step by the bus-clamped beat size
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return burst == BURST_FIXED ? a : a + (32'd1 << (size > MAX_SIZE ? MAX_SIZE : size));
  endfunction

  // write engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_n;
      w_id    <= w_id_n;
      w_addr  <= w_addr_n;
      w_len   <= w_len_n;
      w_size  <= w_size_n;
      w_burst <= w_burst_n;
      w_cnt   <= w_cnt_n;
      w_err   <= w_err_n;
    end
  end

  // write engine: capture AW, consume beats until wlast or awlen, then respond
  always_comb begin
    w_state_n = w_state;
    w_id_n    = w_id;
    w_addr_n  = w_addr;
    w_len_n   = w_len;
    w_size_n  = w_size;
    w_burst_n = w_burst;
    w_cnt_n   = w_cnt;
    w_err_n   = w_err;
    case (w_state)
      W_IDLE: if (axi_mosi_i.awvalid) begin
        w_id_n    = axi_mosi_i.awid;
        w_addr_n  = axi_mosi_i.awaddr;
        w_len_n   = axi_mosi_i.awlen;
        w_size_n  = axi_mosi_i.awsize;
        w_burst_n = axi_mosi_i.awburst;
        w_cnt_n   = '0;
        w_err_n   = 1'b0;
        w_state_n = W_DATA;
      end
      W_DATA: if (axi_mosi_i.wvalid) begin
        w_addr_n  = next_addr(w_addr, w_size, w_burst);
        w_cnt_n   = w_cnt + 8'd1;
        w_err_n   = w_err | !in_range(w_addr) | (axi_mosi_i.wlast != (w_cnt == w_len));
        w_state_n = (axi_mosi_i.wlast || w_cnt == w_len) ? W_RESP : W_DATA;
      end
      W_RESP: if (axi_mosi_i.bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  assign w_we = w_state == W_DATA && axi_mosi_i.wvalid && in_range(w_addr);

  // storage write port, byte-strobed and never reset
  always_ff @(posedge clk) begin
    if (w_we)
      for (int b = 0; b < BPW; b++)
        if (axi_mosi_i.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
  end

  // read engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= r_state_n;
      r_id    <= r_id_n;
      r_addr  <= r_addr_n;
      r_len   <= r_len_n;
      r_size  <= r_size_n;
      r_burst <= r_burst_n;
      r_cnt   <= r_cnt_n;
    end
  end

  // read engine: capture AR, present one beat per rready until the arlen beat
  always_comb begin
    r_state_n = r_state;
    r_id_n    = r_id;
    r_addr_n  = r_addr;
    r_len_n   = r_len;
    r_size_n  = r_size;
    r_burst_n = r_burst;
    r_cnt_n   = r_cnt;
    case (r_state)
      R_IDLE: if (axi_mosi_i.arvalid) begin
        r_id_n    = axi_mosi_i.arid;
        r_addr_n  = axi_mosi_i.araddr;
        r_len_n   = axi_mosi_i.arlen;
        r_size_n  = axi_mosi_i.arsize;
        r_burst_n = axi_mosi_i.arburst;
        r_cnt_n   = '0;
        r_state_n = R_DATA;
      end
      R_DATA: if (axi_mosi_i.rready) begin
        r_addr_n  = next_addr(r_addr, r_size, r_burst);
        r_cnt_n   = r_cnt + 8'd1;
        r_state_n = r_cnt == r_len ? R_IDLE : R_DATA;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  assign r_in = in_range(r_addr);

  // response channels; payload is zero whenever the matching valid is low
  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = w_state == W_IDLE;
    axi_miso_o.wready  = w_state == W_DATA;
    axi_miso_o.bvalid  = w_state == W_RESP;
    axi_miso_o.bid     = w_state == W_RESP ? w_id : '0;
    axi_miso_o.bresp   = (w_state == W_RESP && w_err) ? AXI_SLVERR : AXI_OKAY;
    axi_miso_o.arready = r_state == R_IDLE;
    axi_miso_o.rvalid  = r_state == R_DATA;
    axi_miso_o.rid     = r_state == R_DATA ? r_id : '0;
    axi_miso_o.rdata   = (r_state == R_DATA && r_in) ? mem[word_idx(r_addr)] : '0;
    axi_miso_o.rresp   = (r_state == R_DATA && !r_in) ? AXI_SLVERR : AXI_OKAY;
    axi_miso_o.rlast   = r_state == R_DATA && r_cnt == r_len;
  end
endmodule

// File: doc/dma_axi_mem_slave.md
# dma_axi_mem_slave

AXI4 full-protocol slave memory that answers the DMA master port (`s_axi_mosi_t`/`s_axi_miso_t` from `dma_utils_pkg`). It is the responder end of the DMA's burst read/write traffic and serves as the source/destination RAM in block-level simulation and FPGA bring-up. Independent read and write engines accept one burst each at a time. Each engine supports FIXED and INCR bursts, byte strobes and SLVERR on out-of-range addresses.

## Interface
- `MEM_WORDS`, 1024: memory depth in data-width words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be aligned to `MEM_WORDS*bytes_per_word`.
- `clk`  in  1  single clock; all logic rises on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `axi_mosi_i`  in  `s_axi_mosi_t`  AW/W/B-ready/AR/R-ready from the master.
- `axi_miso_o`  out  `s_axi_miso_t`  awready, wready, bid/bresp/buser/bvalid, arready, rid/rdata/rresp/rlast/ruser/rvalid.

## Operation
- Storage: `MEM_WORDS` × data-width register array.
  - Array is not reset.
  - Word index = `(addr - BASE_ADDR) >> log2(bytes_per_word)`.
  - In range iff `BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*bytes_per_word`.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, capture awid, awaddr, awlen, awsize and awburst, clear beat counter and error flag, then go to W_DATA.
  - W_DATA: wready=1. On each wvalid beat, write the bytes enabled by wstrb at the current address. Out-of-range beats are dropped and set the error flag. Then the address advances (see below) and the beat counter increments.
  - W_DATA exits on wlast beat to W_RESP. If wlast arrives with count≠awlen, or count reaches awlen without wlast, set the error flag.
  - W_DATA with count==awlen and no wlast: the beat is still written and the FSM goes to W_RESP anyway.
  - W_RESP: bvalid=1, bid=captured id, bresp=SLVERR (2'b10) if error else OKAY. On bready, go to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, capture arid, araddr, arlen, arsize and arburst, then go to R_DATA.
  - R_DATA: rvalid=1, rid=captured id, rdata=mem[current index] (combinational array read).
    - rresp=OKAY for in-range beats.
    - Out-of-range beats return rdata=0 with rresp=SLVERR.
    - rlast=1 when beat count==arlen.
    - On rready the address advances; if rlast, go to R_IDLE.
- Address advance: INCR adds `1<<size`; FIXED holds. WRAP (2'b10) is treated as INCR; this is intentional because the DMA never issues WRAP. Arithmetic is 32-bit and wraps modulo 2^32.
- Sizes larger than the bus width are clamped to the bus width.
- Unaligned start addresses: the word index is computed by truncation and strobes are honoured as given.
- buser/ruser are always 0.
- The read and write engines are fully concurrent. If both touch the same word in the same cycle, the read returns the pre-write data and the write commits at that edge.

## Timing
- Reset values while rst=1 and immediately after release:
  - awready=1, arready=1;
  - wready=0, bvalid=0, rvalid=0, rlast=0;
  - bresp=rresp=0, bid=rid=0, rdata=0.
  - Both FSMs are in IDLE.
- AW handshake at edge N: wready=1 from cycle N+1. W beats are accepted at one per cycle with no bubbles.
- Last W beat at edge M: bvalid=1 in cycle M+1. bvalid is held until bready, and awready returns one cycle after the B handshake. Write throughput is therefore burst+2 cycles minimum.
- AR handshake at edge N: first rvalid in cycle N+1, then one beat per cycle while rready=1. arready returns the cycle after the rlast handshake.
- awready/arready are deasserted for the whole burst, so a new AW/AR is never accepted while the previous one is busy.
- Once asserted, valid and payload are held stable until handshake.
- Asynchronous reset mid-burst aborts the burst immediately. Memory contents written before reset are preserved.
- awlen=0 (single beat) takes the same path, with first beat == last beat.

## Test plan
- INCR write, awaddr=0x10, awlen=3, size=2, data 0xA0..0xA3, wstrb=4'hF -> bresp=OKAY, bid echoes awid. Then INCR read of the same range -> rdata 0xA0..0xA3, rlast on beat 3 only.
- Strobe test: write 0xFFFF_FFFF then 0x1234_5678 with wstrb=4'b0101 to 0x40 -> read returns 0xFF34_FF78.
- FIXED read of 4 beats at 0x20 -> the same word is returned 4 times. FIXED write of 4 beats -> only the last data remains.
- Out of range: INCR write starting at the last word with awlen=1 -> the in-range beat is written and bresp=SLVERR. A read of the same span gives beat0 OKAY and beat1 rdata=0, SLVERR.
- Backpressure: random rready/bready stalls across a 16-beat read and a concurrent 16-beat write to disjoint regions -> data intact and valid/payload stable during stalls.
- Reset asserted mid-read (beat 2 of 8) -> rvalid=0 that cycle, arready=1 after release, and a previously written word reads back unchanged.
